// File: rtl/pkt_tx_arbiter_pkg.sv
// Shared definitions for the packet transmit arbiter: word layout, position codes
// and FSM state encodings.
package pkt_tx_arbiter_pkg;

    localparam int WIDTH = 134;

    localparam logic [1:0] POS_MID    = 2'b00;
    localparam logic [1:0] POS_HEAD   = 2'b01;
    localparam logic [1:0] POS_TAIL   = 2'b10;
    localparam logic [1:0] POS_SINGLE = 2'b11;

    typedef enum logic {
        ARB_IDLE,
        ARB_SEND
    } arb_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WRITE,
        WR_DROP
    } wr_state_t;

    // Bit 0 of the position code marks a packet start, bit 1 a packet end.
    function automatic logic is_head(input logic [1:0] code);
        return code[0];
    endfunction

    function automatic logic is_last(input logic [1:0] code);
        return code[1];
    endfunction

endpackage

// File: rtl/pkt_commit_fifo.sv
// Store-and-forward packet buffer: words become readable only once their tail is
// written; partial or oversized packets are rolled back and reported on drop.
module pkt_commit_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = pkt_tx_arbiter_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             avail,
    output logic             drop
);
    import pkt_tx_arbiter_pkg::*;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, start_ptr, commit_ptr, rd_ptr;
    wr_state_t             state;

    logic [DEPTH_LOG2-1:0] wr_ptr_n, start_ptr_n, commit_ptr_n, wr_addr, base;
    wr_state_t             state_n;
    logic                  wr_en, drop_n, start_new;
    logic [1:0]            code;

    assign code = in_data[WIDTH-1 -: 2];

    always_comb begin
        wr_ptr_n     = wr_ptr;
        start_ptr_n  = start_ptr;
        commit_ptr_n = commit_ptr;
        state_n      = state;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr;
        drop_n       = 1'b0;
        start_new    = 1'b0;
        base         = wr_ptr;
        if (in_valid) begin
            case (state)
                WR_IDLE: begin
                    start_new = is_head(code);
                end
                WR_WRITE: begin
                    if (is_head(code)) begin
                        // Missing tail: discard the partial packet and restart here.
                        drop_n    = 1'b1;
                        start_new = 1'b1;
                        base      = start_ptr;
                    end else if ((wr_ptr + 1'b1) == rd_ptr) begin
                        wr_ptr_n = start_ptr;
                        state_n  = WR_DROP;
                        drop_n   = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_n = wr_ptr + 1'b1;
                        if (is_last(code)) begin
                            commit_ptr_n = wr_ptr + 1'b1;
                            state_n      = WR_IDLE;
                        end
                    end
                end
                WR_DROP: begin
                    if (is_head(code)) begin
                        start_new = 1'b1;
                    end else if (is_last(code)) begin
                        state_n = WR_IDLE;
                    end
                end
                default: state_n = WR_IDLE;
            endcase
        end
        if (start_new) begin
            start_ptr_n = base;
            if ((base + 1'b1) == rd_ptr) begin
                wr_ptr_n = base;
                state_n  = WR_DROP;
                drop_n   = 1'b1;
            end else begin
                wr_en    = 1'b1;
                wr_addr  = base;
                wr_ptr_n = base + 1'b1;
                if (is_last(code)) begin
                    commit_ptr_n = base + 1'b1;
                    state_n      = WR_IDLE;
                end else begin
                    state_n      = WR_WRITE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            start_ptr  <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            state      <= WR_IDLE;
            drop       <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            start_ptr  <= start_ptr_n;
            commit_ptr <= commit_ptr_n;
            state      <= state_n;
            drop       <= drop_n;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    assign dout  = mem[rd_ptr];
    assign avail = (rd_ptr != commit_ptr);

endmodule

// File: rtl/pkt_tx_arbiter.sv
// Packet-atomic round-robin merge of two committed packet buffers onto one stream.
// Define PKT_TX_ARB_STATS_EN to add per-source dropped-packet counters.
module pkt_tx_arbiter #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = pkt_tx_arbiter_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             data_out_valid,
    output logic [WIDTH-1:0] data_out,
    input  logic             out_ready
`ifdef PKT_TX_ARB_STATS_EN
    ,
    output logic [31:0]      drop_cnt0,
    output logic [31:0]      drop_cnt1
`endif
);
    import pkt_tx_arbiter_pkg::*;

    logic [WIDTH-1:0] dout0, dout1;
    logic [1:0]       avail, pop, drop;

    pkt_commit_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) u_fifo0 (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in0_valid),
        .in_data  (in0_data),
        .pop      (pop[0]),
        .dout     (dout0),
        .avail    (avail[0]),
        .drop     (drop[0])
    );

    pkt_commit_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) u_fifo1 (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in1_valid),
        .in_data  (in1_data),
        .pop      (pop[1]),
        .dout     (dout1),
        .avail    (avail[1]),
        .drop     (drop[1])
    );

    arb_state_t arb_state;
    logic       grant, last_grant, sel, accept, last_word;

    // The source that did not send last gets priority when it has a packet ready.
    assign sel       = avail[~last_grant] ? ~last_grant : last_grant;
    assign accept    = data_out_valid && out_ready;
    assign last_word = is_last(data_out[WIDTH-1 -: 2]);

    always_comb begin
        pop = 2'b00;
        if (arb_state == ARB_IDLE) begin
            if (|avail) begin
                pop[sel] = 1'b1;
            end
        end else if (accept && !last_word) begin
            pop[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            arb_state      <= ARB_IDLE;
            grant          <= 1'b0;
            last_grant     <= 1'b1;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else begin
            case (arb_state)
                ARB_IDLE: begin
                    if (|avail) begin
                        grant          <= sel;
                        data_out       <= sel ? dout1 : dout0;
                        data_out_valid <= 1'b1;
                        arb_state      <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    if (accept) begin
                        if (last_word) begin
                            data_out_valid <= 1'b0;
                            last_grant     <= grant;
                            arb_state      <= ARB_IDLE;
                        end else begin
                            data_out <= grant ? dout1 : dout0;
                        end
                    end
                end
                default: arb_state <= ARB_IDLE;
            endcase
        end
    end

`ifdef PKT_TX_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt0 <= '0;
            drop_cnt1 <= '0;
        end else begin
            if (drop[0]) begin
                drop_cnt0 <= drop_cnt0 + 32'd1;
            end
            if (drop[1]) begin
                drop_cnt1 <= drop_cnt1 + 32'd1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = ^drop;
`endif

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Directed bench for pkt_tx_arbiter: latency, arbitration order, backpressure,
// overflow and missing-tail drops, and reset mid-packet.
module tb_pkt_tx_arbiter;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in0_valid = 1'b0;
    logic [133:0] in0_data = '0;
    logic         in1_valid = 1'b0;
    logic [133:0] in1_data = '0;
    logic         data_out_valid;
    logic [133:0] data_out;
    logic         out_ready = 1'b1;
`ifdef PKT_TX_ARB_STATS_EN
    logic [31:0]  drop_cnt0, drop_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [133:0] mon_q [$];
    int           mon_cyc [$];
    logic [133:0] exp_q [$];

    pkt_tx_arbiter #(.DEPTH_LOG2(6), .WIDTH(134)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in0_valid      (in0_valid),
        .in0_data       (in0_data),
        .in1_valid      (in1_valid),
        .in1_data       (in1_data),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .out_ready      (out_ready)
`ifdef PKT_TX_ARB_STATS_EN
        ,
        .drop_cnt0      (drop_cnt0),
        .drop_cnt1      (drop_cnt1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A word seen valid and ready at the falling edge is taken at the next rising edge.
    always @(negedge clk) begin
        if (resetn && data_out_valid && out_ready) begin
            mon_q.push_back(data_out);
            mon_cyc.push_back(cyc);
        end
    end

    function automatic logic [133:0] mkw(input logic [1:0] code, input logic [7:0] tag);
        return {code, 4'hF, {15{tag}}, tag};
    endfunction

    task automatic check_eq(input string tag, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int src, input logic [133:0] w);
        if (src == 0) begin
            in0_valid = 1'b1;
            in0_data  = w;
        end else begin
            in1_valid = 1'b1;
            in1_data  = w;
        end
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic drive_both(input logic [133:0] a, input logic [133:0] b);
        in0_valid = 1'b1;
        in0_data  = a;
        in1_valid = 1'b1;
        in1_data  = b;
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        mon_q.delete();
        mon_cyc.delete();
    endtask

    task automatic check_pkt(input string tag);
        check_eq({tag, "_count"}, 134'(mon_q.size()), 134'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            check_eq($sformatf("%s_w%0d", tag, i), mon_q[i], exp_q[i]);
        end
        mon_q.delete();
        mon_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [1:0] codes3 [3];
        logic [1:0] codes4 [4];
        int         n_before;
        codes3 = '{2'b01, 2'b00, 2'b10};
        codes4 = '{2'b01, 2'b00, 2'b00, 2'b10};

        // Reset state
        do_reset();
        check_eq("rst_valid", 134'(data_out_valid), 134'(0));
        check_eq("rst_data", data_out, '0);

        // 4-word packet on source 0: head appears one edge after the tail edge
        for (int i = 0; i < 4; i++) drive(0, mkw(codes4[i], 8'h10 + 8'(i)));
        check_eq("lat_no_early", 134'(data_out_valid), 134'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("lat_valid%0d", i), 134'(data_out_valid), 134'(1));
            check_eq($sformatf("lat_data%0d", i), data_out, mkw(codes4[i], 8'h10 + 8'(i)));
        end
        tick();
        check_eq("lat_end_valid", 134'(data_out_valid), 134'(0));

        // Tie after reset: source 0 first, one bubble, then source 1
        do_reset();
        for (int i = 0; i < 3; i++)
            drive_both(mkw(codes3[i], 8'hA0 + 8'(i)), mkw(codes3[i], 8'hB0 + 8'(i)));
        repeat (16) tick();
        check_eq("tie1_gap_in_pkt", 134'(mon_cyc.size() > 3 ? mon_cyc[1] - mon_cyc[0] : 0), 134'(1));
        check_eq("tie1_bubble", 134'(mon_cyc.size() > 3 ? mon_cyc[3] - mon_cyc[2] : 0), 134'(2));
        for (int i = 0; i < 3; i++) exp_q.push_back(mkw(codes3[i], 8'hA0 + 8'(i)));
        for (int i = 0; i < 3; i++) exp_q.push_back(mkw(codes3[i], 8'hB0 + 8'(i)));
        check_pkt("tie1");

        // Single-word packet from source 0 leaves last_grant = 0
        drive(0, mkw(2'b11, 8'hC0));
        repeat (6) tick();
        exp_q.push_back(mkw(2'b11, 8'hC0));
        check_pkt("single");

        // Tie again: source 1 now wins
        for (int i = 0; i < 3; i++)
            drive_both(mkw(codes3[i], 8'hD0 + 8'(i)), mkw(codes3[i], 8'hE0 + 8'(i)));
        repeat (16) tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(mkw(codes3[i], 8'hE0 + 8'(i)));
        for (int i = 0; i < 3; i++) exp_q.push_back(mkw(codes3[i], 8'hD0 + 8'(i)));
        check_pkt("tie2");

        // Backpressure mid-packet on source 1
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(1, mkw(codes4[i], 8'h30 + 8'(i)));
        tick();
        check_eq("bp_head", data_out, mkw(codes4[0], 8'h30));
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("bp_hold_valid%0d", i), 134'(data_out_valid), 134'(1));
            check_eq($sformatf("bp_hold_data%0d", i), data_out, mkw(codes4[2], 8'h32));
        end
        out_ready = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 4; i++) exp_q.push_back(mkw(codes4[i], 8'h30 + 8'(i)));
        check_pkt("bp");

        // 70-word packet overflows the 63-word buffer; the next packet survives
        drive(1, mkw(2'b01, 8'h50));
        for (int i = 1; i < 69; i++) drive(1, mkw(2'b00, 8'h50 + 8'(i)));
        drive(1, mkw(2'b10, 8'h99));
        repeat (4) tick();
        check_eq("ovf_nothing_out", 134'(mon_q.size()), 134'(0));
        drive(1, mkw(2'b01, 8'h60));
        drive(1, mkw(2'b10, 8'h61));
        repeat (6) tick();
        exp_q.push_back(mkw(2'b01, 8'h60));
        exp_q.push_back(mkw(2'b10, 8'h61));
        check_pkt("ovf_next");
`ifdef PKT_TX_ARB_STATS_EN
        check_eq("ovf_drop_cnt1", 134'(drop_cnt1), 134'(1));
`endif

        // Missing tail on source 0: only the second packet is forwarded
        drive(0, mkw(2'b01, 8'h70));
        drive(0, mkw(2'b00, 8'h71));
        drive(0, mkw(2'b01, 8'h72));
        drive(0, mkw(2'b10, 8'h73));
        repeat (6) tick();
        exp_q.push_back(mkw(2'b01, 8'h72));
        exp_q.push_back(mkw(2'b10, 8'h73));
        check_pkt("rollback");
`ifdef PKT_TX_ARB_STATS_EN
        check_eq("rb_drop_cnt0", 134'(drop_cnt0), 134'(1));
`endif

        // Reset while source 1 is mid-output
        drive(1, mkw(2'b01, 8'h80));
        for (int i = 1; i < 5; i++) drive(1, mkw(2'b00, 8'h80 + 8'(i)));
        drive(1, mkw(2'b10, 8'h85));
        tick();
        tick();
        tick();
        check_eq("rst_mid_valid_before", 134'(data_out_valid), 134'(1));
        n_before = mon_q.size();
        resetn = 1'b0;
        tick();
        check_eq("rst_mid_valid", 134'(data_out_valid), 134'(0));
        check_eq("rst_mid_data", data_out, '0);
        resetn = 1'b1;
        repeat (10) tick();
        check_eq("rst_mid_after_valid", 134'(data_out_valid), 134'(0));
        check_eq("rst_mid_no_residual", 134'(mon_q.size()), 134'(n_before));
        check_eq("rst_mid_words_before", 134'(n_before), 134'(2));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
